// File: rtl/pipe_ctrl_pkg.sv
// Shared decode/hazard definitions: opcodes, control sub-ops, forward-select
// encodings, hazard FSM states and scoreboard entry layout.
package pipe_ctrl_pkg;

  localparam int RIDX_W = 5;
  localparam int OPC_W  = 6;
  localparam int SB_N   = 3;

  localparam logic [OPC_W-1:0] OPC_ADD   = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_SUB   = 6'b000001;
  localparam logic [OPC_W-1:0] OPC_AND   = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_OR    = 6'b000011;
  localparam logic [OPC_W-1:0] OPC_XOR   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_NOT   = 6'b000101;
  localparam logic [OPC_W-1:0] OPC_SHL   = 6'b000110;
  localparam logic [OPC_W-1:0] OPC_SHR   = 6'b000111;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_MUL   = 6'b001001;
  localparam logic [OPC_W-1:0] OPC_CMP   = 6'b001010;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 6'b001011;
  localparam logic [OPC_W-1:0] OPC_STORE = 6'b001100;
  localparam logic [OPC_W-1:0] OPC_CTRL  = 6'b001111;

  // Control instructions carry their sub-op in the rd field.
  localparam logic [RIDX_W-1:0] RD_JMP = 5'd0;
  localparam logic [RIDX_W-1:0] RD_BEQ = 5'd1;
  localparam logic [RIDX_W-1:0] RD_BLT = 5'd2;
  localparam logic [RIDX_W-1:0] RD_BGT = 5'd3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hzd_state_t;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rd;
    logic              we;
    logic              ld;
  } sb_entry_t;

  // Observation bundle: FSM state plus per-entry (E=0, M=1, W=2) hit/load flags.
  typedef struct packed {
    hzd_state_t      state;
    logic [SB_N-1:0] hit_a;
    logic [SB_N-1:0] hit_b;
    logic [SB_N-1:0] sb_ld;
  } hzd_dbg_t;

  // Returns {use_a, use_b}. JMP reads nothing; NOT and LOAD do not read rb.
  function automatic logic [1:0] src_use(
    input logic [OPC_W-1:0]  opc,
    input logic [RIDX_W-1:0] rd,
    input logic              is_ld,
    input logic              is_str,
    input logic              is_brn
  );
    logic jmp;
    logic no_b;
    jmp  = is_brn & (rd == RD_JMP);
    no_b = is_ld | (opc == OPC_LOAD) | (opc == OPC_NOT);
    return {~jmp, ~jmp & (is_str | ~no_b)};
  endfunction

endpackage

// File: rtl/pipe_hzd_cmp.sv
// One scoreboard entry compared against the D-stage source indices.
module pipe_hzd_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic              valid,
  input  logic              we,
  input  logic [RIDX_W-1:0] rd,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic              use_a,
  input  logic              use_b,
  output logic              match_a,
  output logic              match_b
);

  logic writer;

  assign writer  = valid & we;
  assign match_a = writer & use_a & (rd == ra);
  assign match_b = writer & use_b & (rd == rb);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode/execute hazard controller: E/M/W destination scoreboard, stall/flush/bubble
// controls and registered E-operand forward selects. Forwarding enabled by PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_valid,
  input  logic [OPC_W-1:0]  D_opc,
  input  logic [RIDX_W-1:0] D_ra,
  input  logic [RIDX_W-1:0] D_rb,
  input  logic [RIDX_W-1:0] D_rd,
  input  logic              D_we,
  input  logic              D_ld,
  input  logic              D_str,
  input  logic              D_brn,
  input  logic              E_brn_taken,
  output logic              F_stall,
  output logic              D_stall,
  output logic              E_bubble,
  output logic              F_flush,
  output logic [1:0]        E_fwd_a,
  output logic [1:0]        E_fwd_b,
  output logic              sb_busy,
  output hzd_dbg_t          dbg
);

  if (NREG != (1 << RIDX_W) || XLEN < 8) begin : g_param_chk
    $error("pipe_hazard_ctrl: NREG must equal %0d and XLEN must be >= 8", 1 << RIDX_W);
  end

  hzd_state_t      state;
  hzd_state_t      state_nxt;
  sb_entry_t       sb [SB_N];
  sb_entry_t       d_entry;
  logic            use_a;
  logic            use_b;
  logic            d_live;
  logic            hazard;
  logic            issue;
  logic [SB_N-1:0] hit_a;
  logic [SB_N-1:0] hit_b;
  logic [SB_N-1:0] sb_ld;
  logic [SB_N-1:0] sb_wr;

  assign {use_a, use_b} = src_use(D_opc, D_rd, D_ld, D_str, D_brn);

  // The redirect target has not reached D during FLUSH, so D content is stale.
  assign d_live = D_valid & (state != FLUSH);
  assign issue  = d_live & ~E_bubble;

  for (genvar i = 0; i < SB_N; i++) begin : g_cmp
    pipe_hzd_cmp u_cmp (
      .valid   (sb[i].valid),
      .we      (sb[i].we),
      .rd      (sb[i].rd),
      .ra      (D_ra),
      .rb      (D_rb),
      .use_a   (use_a),
      .use_b   (use_b),
      .match_a (hit_a[i]),
      .match_b (hit_b[i])
    );
    assign sb_ld[i] = sb[i].ld;
    assign sb_wr[i] = sb[i].valid & sb[i].we;
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;

  // Only a load still in E cannot be forwarded in time.
  assign hazard = d_live & sb_ld[0] & (hit_a[0] | hit_b[0]);

  // Producer in E now sits in M when the consumer reaches E; M moves to W.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (hit_a[0])      sel_a = FWD_M;
    else if (hit_a[1]) sel_a = FWD_W;
    if (hit_b[0])      sel_b = FWD_M;
    else if (hit_b[1]) sel_b = FWD_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (issue) begin
      fwd_a_q <= sel_a;
      fwd_b_q <= sel_b;
    end else begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end
  end

  assign E_fwd_a = fwd_a_q;
  assign E_fwd_b = fwd_b_q;
`else
  // Without forwarding any in-flight writer of a used source holds D.
  assign hazard  = d_live & ((|hit_a) | (|hit_b));
  assign E_fwd_a = FWD_RF;
  assign E_fwd_b = FWD_RF;
`endif

  always_comb begin
    d_entry       = '0;
    d_entry.valid = 1'b1;
    d_entry.rd    = D_rd;
    d_entry.we    = D_we;
    d_entry.ld    = D_ld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb[0] <= '0;
      sb[1] <= '0;
      sb[2] <= '0;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= issue ? d_entry : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    if (E_brn_taken) state_nxt = FLUSH;
    else if (hazard) state_nxt = STALL;
  end

  // A taken branch overrides any stall: D and F are squashed instead of held.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_bubble = 1'b0;
    F_flush  = 1'b0;
    if (E_brn_taken) begin
      F_flush  = 1'b1;
      E_bubble = 1'b1;
    end else if (state == FLUSH) begin
      E_bubble = 1'b1;
    end else if (hazard) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
    end
  end

  assign sb_busy = |sb_wr;

  always_comb begin
    dbg       = '0;
    dbg.state = state;
    dbg.hit_a = hit_a;
    dbg.hit_b = hit_b;
    dbg.sb_ld = sb_ld;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow PIPE_HAZARD_FWD_EN when defined.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int EXP_W = 11;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_STL = 2'd1;
  localparam logic [1:0] S_FL  = 2'd2;

  typedef struct packed {
    logic       v;
    logic [5:0] opc;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       str;
    logic       brn;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       D_valid = 1'b0;
  logic [5:0] D_opc = '0;
  logic [4:0] D_ra = '0;
  logic [4:0] D_rb = '0;
  logic [4:0] D_rd = '0;
  logic       D_we = 1'b0;
  logic       D_ld = 1'b0;
  logic       D_str = 1'b0;
  logic       D_brn = 1'b0;
  logic       E_brn_taken = 1'b0;
  logic       F_stall, D_stall, E_bubble, F_flush, sb_busy;
  logic [1:0] E_fwd_a, E_fwd_b;
  hzd_dbg_t   dbg;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_chk = 0;
  int               n_pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_opc(D_opc), .D_ra(D_ra), .D_rb(D_rb),
    .D_rd(D_rd), .D_we(D_we), .D_ld(D_ld), .D_str(D_str), .D_brn(D_brn),
    .E_brn_taken(E_brn_taken), .F_stall(F_stall), .D_stall(D_stall), .E_bubble(E_bubble),
    .F_flush(F_flush), .E_fwd_a(E_fwd_a), .E_fwd_b(E_fwd_b), .sb_busy(sb_busy), .dbg(dbg)
  );

  function automatic instr_t i_idle();
    return '0;
  endfunction

  function automatic instr_t i_alu(input logic [5:0] opc, input logic [4:0] rd, ra, rb);
    instr_t i = '0;
    i.v = 1'b1; i.opc = opc; i.rd = rd; i.ra = ra; i.rb = rb; i.we = 1'b1;
    return i;
  endfunction

  function automatic instr_t i_load(input logic [4:0] rd, ra);
    instr_t i = '0;
    i.v = 1'b1; i.opc = OPC_LOAD; i.rd = rd; i.ra = ra; i.we = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t i_br(input logic [4:0] sub, ra, rb);
    instr_t i = '0;
    i.v = 1'b1; i.opc = OPC_CTRL; i.rd = sub; i.ra = ra; i.rb = rb; i.brn = 1'b1;
    return i;
  endfunction

  // Expected vector: {F_stall, D_stall, E_bubble, F_flush, E_fwd_a, E_fwd_b, sb_busy, state}
  function automatic logic [EXP_W-1:0] ex(input logic fs, ds, eb, ff, input logic [1:0] fa, fb,
                                          input logic busy, input logic [1:0] st);
    return {fs, ds, eb, ff, fa, fb, busy, st};
  endfunction

  function automatic logic [EXP_W-1:0] ex_z(input logic busy, input logic [1:0] st);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, busy, st);
  endfunction

  function automatic logic [EXP_W-1:0] ex_stl(input logic busy, input logic [1:0] st);
    return ex(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, busy, st);
  endfunction

  task automatic cyc(input instr_t ins, input logic taken, input logic r, input logic chk,
                     input logic [EXP_W-1:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r;
    D_valid = ins.v; D_opc = ins.opc; D_ra = ins.ra; D_rb = ins.rb; D_rd = ins.rd;
    D_we = ins.we; D_ld = ins.ld; D_str = ins.str; D_brn = ins.brn;
    E_brn_taken = taken;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic step(input instr_t ins, input logic [EXP_W-1:0] e, input string nm);
    cyc(ins, 1'b0, 1'b0, 1'b1, e, nm);
  endtask

  task automatic do_reset();
    cyc(i_idle(), 1'b0, 1'b1, 1'b0, '0, "");
    cyc(i_idle(), 1'b0, 1'b1, 1'b1, ex_z(1'b0, S_RUN), "reset");
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] act;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {F_stall, D_stall, E_bubble, F_flush, E_fwd_a, E_fwd_b, sb_busy, 2'(dbg.state)};
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %b required %b (fs ds eb ff fa fb busy st)", nm, act, e);
    end
  end

  initial begin
    do_reset();

    // Back-to-back dependent ALU ops
    step(i_alu(OPC_ADD, 5'd3, 5'd1, 5'd2), ex_z(1'b0, S_RUN), "add_issue");
`ifdef PIPE_HAZARD_FWD_EN
    step(i_alu(OPC_SUB, 5'd4, 5'd3, 5'd5), ex_z(1'b1, S_RUN), "sub_no_stall");
    step(i_idle(), ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, S_RUN), "sub_fwd_a");
`else
    step(i_alu(OPC_SUB, 5'd4, 5'd3, 5'd5), ex_stl(1'b1, S_RUN), "sub_stall_1");
    step(i_alu(OPC_SUB, 5'd4, 5'd3, 5'd5), ex_stl(1'b1, S_STL), "sub_stall_2");
    step(i_alu(OPC_SUB, 5'd4, 5'd3, 5'd5), ex_stl(1'b1, S_STL), "sub_stall_3");
    step(i_alu(OPC_SUB, 5'd4, 5'd3, 5'd5), ex_z(1'b0, S_STL), "sub_issue");
    step(i_idle(), ex_z(1'b1, S_RUN), "sub_in_e");
`endif

    // Load-use
    do_reset();
    step(i_load(5'd6, 5'd11), ex_z(1'b0, S_RUN), "ld_issue");
`ifdef PIPE_HAZARD_FWD_EN
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), ex_stl(1'b1, S_RUN), "ld_use_stall");
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), ex_z(1'b1, S_STL), "ld_use_release");
    step(i_idle(), ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, S_RUN), "ld_use_fwd_w");
`else
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), ex_stl(1'b1, S_RUN), "ld_use_stall");
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), ex_stl(1'b1, S_STL), "ld_stall_2");
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), ex_stl(1'b1, S_STL), "ld_stall_3");
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), ex_z(1'b0, S_STL), "ld_use_release");
    step(i_idle(), ex_z(1'b1, S_RUN), "add_in_e");
`endif

    // Producer two ahead, consumer on rb
    do_reset();
    step(i_alu(OPC_ADD, 5'd3, 5'd1, 5'd2), ex_z(1'b0, S_RUN), "add_r3");
    step(i_idle(), ex_z(1'b1, S_RUN), "gap");
`ifdef PIPE_HAZARD_FWD_EN
    step(i_alu(OPC_XOR, 5'd8, 5'd1, 5'd3), ex_z(1'b1, S_RUN), "xor_no_stall");
    step(i_idle(), ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, S_RUN), "xor_fwd_b");
`else
    step(i_alu(OPC_XOR, 5'd8, 5'd1, 5'd3), ex_stl(1'b1, S_RUN), "xor_stall_1");
    step(i_alu(OPC_XOR, 5'd8, 5'd1, 5'd3), ex_stl(1'b1, S_STL), "xor_stall_2");
    step(i_alu(OPC_XOR, 5'd8, 5'd1, 5'd3), ex_z(1'b0, S_STL), "xor_issue");
    step(i_idle(), ex_z(1'b1, S_RUN), "xor_in_e");
`endif

    // NOT ignores rb even when rb names an in-flight destination
    do_reset();
    step(i_alu(OPC_ADD, 5'd3, 5'd1, 5'd2), ex_z(1'b0, S_RUN), "add_r3_b");
    step(i_alu(OPC_NOT, 5'd9, 5'd1, 5'd3), ex_z(1'b1, S_RUN), "not_no_stall");
    step(i_idle(), ex_z(1'b1, S_RUN), "not_fwd_b");

    // Taken branch coinciding with a load-use hazard
    do_reset();
    step(i_load(5'd6, 5'd11), ex_z(1'b0, S_RUN), "ld_issue_b");
    cyc(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1), 1'b1, 1'b0, 1'b1,
        ex(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, S_RUN), "flush_wins");
    step(i_alu(OPC_ADD, 5'd7, 5'd6, 5'd1),
         ex(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, S_FL), "flush_state");
    step(i_idle(), ex_z(1'b1, S_RUN), "flush_exit");
    step(i_idle(), ex_z(1'b0, S_RUN), "flush_drop");

    // Reset with three writers in flight
    do_reset();
    step(i_alu(OPC_ADD, 5'd1, 5'd20, 5'd21), ex_z(1'b0, S_RUN), "wr1");
    step(i_alu(OPC_ADD, 5'd2, 5'd22, 5'd23), ex_z(1'b1, S_RUN), "wr2");
    step(i_alu(OPC_ADD, 5'd10, 5'd24, 5'd25), ex_z(1'b1, S_RUN), "wr3");
    cyc(i_idle(), 1'b0, 1'b1, 1'b1, ex_z(1'b1, S_RUN), "pre_reset_busy");
    step(i_idle(), ex_z(1'b0, S_RUN), "reset_in_flight");

    // JMP reads nothing; BEQ operands follow ALU rules
    do_reset();
    step(i_alu(OPC_ADD, 5'd3, 5'd1, 5'd2), ex_z(1'b0, S_RUN), "add_r3_c");
    step(i_br(RD_JMP, 5'd3, 5'd3), ex_z(1'b1, S_RUN), "jmp_no_stall");
`ifdef PIPE_HAZARD_FWD_EN
    step(i_br(RD_BEQ, 5'd4, 5'd3), ex_z(1'b1, S_RUN), "beq_no_stall");
    step(i_idle(), ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, S_RUN), "beq_fwd_b");
`else
    step(i_br(RD_BEQ, 5'd4, 5'd3), ex_stl(1'b1, S_RUN), "beq_stall_1");
    step(i_br(RD_BEQ, 5'd4, 5'd3), ex_stl(1'b1, S_STL), "beq_stall_2");
    step(i_br(RD_BEQ, 5'd4, 5'd3), ex_z(1'b0, S_STL), "beq_issue");
    step(i_idle(), ex_z(1'b0, S_RUN), "beq_in_e");
`endif

    cyc(i_idle(), 1'b0, 1'b0, 1'b0, '0, "");
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d checks left unread, required 0", exp_q.size());
      n_chk += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
